// File: rtl/snp_bus_ctrl_if.sv
// Snoop-bus channel bundle: sd/su request/response to the requester plus
// the snoop request/response pair to the peer cache.
interface snp_bus_ctrl_if #(
   parameter int unsigned SADDR_WIDTH = 58,
   parameter int unsigned BLK_WIDTH   = 512
);
   logic                   sdreq_valid;
   logic [2:0]             sdreq_op;
   logic [SADDR_WIDTH-1:0] sdreq_addr;
   logic [BLK_WIDTH-1:0]   sdreq_data;
   logic                   sdreq_ready;

   logic                   sursp_valid;
   logic [2:0]             sursp_rsp;
   logic [BLK_WIDTH-1:0]   sursp_data;
   logic                   sursp_ready;

   logic                   sureq_valid;
   logic [1:0]             sureq_op;
   logic [SADDR_WIDTH-1:0] sureq_addr;
   logic                   sureq_ready;

   logic                   sdrsp_valid;
   logic [1:0]             sdrsp_rsp;
   logic [BLK_WIDTH-1:0]   sdrsp_data;
   logic                   sdrsp_ready;

   // Controller side
   modport master (
      input  sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
      output sdreq_ready,
      output sursp_valid, sursp_rsp, sursp_data,
      input  sursp_ready,
      output sureq_valid, sureq_op, sureq_addr,
      input  sureq_ready,
      input  sdrsp_valid, sdrsp_rsp, sdrsp_data,
      output sdrsp_ready
   );

   // Requesting cache / peer cache side
   modport slave (
      output sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
      input  sdreq_ready,
      input  sursp_valid, sursp_rsp, sursp_data,
      output sursp_ready,
      input  sureq_valid, sureq_op, sureq_addr,
      output sureq_ready,
      output sdrsp_valid, sdrsp_rsp, sdrsp_data,
      input  sdrsp_ready
   );
endinterface

// File: rtl/snp_bus_ctrl.sv
// Blocking snoop-bus controller: one request at a time, snoops a single peer,
// then reads/updates a backing block memory and returns the response.
module snp_bus_ctrl #(
   parameter int unsigned PADDR_WIDTH = 64,
   parameter int unsigned BLK_WIDTH   = 512,
   parameter int unsigned SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8),
   parameter int unsigned MEM_DEPTH   = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   snp_bus_ctrl_if.master   bus
);
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   localparam logic [2:0] OP_RD  = 3'd0;
   localparam logic [2:0] OP_RFO = 3'd1;
   localparam logic [2:0] OP_INV = 3'd2;
   localparam logic [2:0] OP_WB  = 3'd3;

   localparam logic [2:0] RSP_ACK   = 3'd0;
   localparam logic [2:0] RSP_GNT_S = 3'd1;
   localparam logic [2:0] RSP_GNT_E = 3'd2;
   localparam logic [2:0] RSP_GNT_M = 3'd3;
   localparam logic [2:0] RSP_ERR   = 3'd4;

   localparam logic [1:0] SNP_RD  = 2'd0;
   localparam logic [1:0] SNP_INV = 2'd1;

   localparam logic [1:0] SR_HIT_CLEAN = 2'd1;
   localparam logic [1:0] SR_HIT_DIRTY = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SNOOP, ST_WAIT_SNP, ST_MEM, ST_RSP
   } state_t;

   state_t                 state_q;
   logic [2:0]             op_q;
   logic [SADDR_WIDTH-1:0] addr_q;
   logic [BLK_WIDTH-1:0]   data_q;
   logic [1:0]             snp_rsp_q;
   logic [BLK_WIDTH-1:0]   snp_data_q;

   logic                   sdreq_ready_q;
   logic                   sureq_valid_q;
   logic [1:0]             sureq_op_q;
   logic                   sdrsp_ready_q;
   logic                   sursp_valid_q;
   logic [2:0]             sursp_rsp_q;
   logic [BLK_WIDTH-1:0]   sursp_data_q;

   // Memory data is never reset; a per-block valid bit makes unwritten blocks read as 0
   logic [BLK_WIDTH-1:0]   mem [MEM_DEPTH];
   logic [MEM_DEPTH-1:0]   mem_vld;

   logic [IDX_W-1:0]       idx_c;
   logic [BLK_WIDTH-1:0]   mem_rd_c;
   logic [2:0]             rsp_c;
   logic [BLK_WIDTH-1:0]   rdata_c;
   logic                   we_c;
   logic [BLK_WIDTH-1:0]   wdata_c;

   assign idx_c = addr_q[IDX_W-1:0];

   // MEM-cycle decision: response code, returned data and memory update
   always_comb begin
      mem_rd_c = mem_vld[idx_c] ? mem[idx_c] : '0;
      rsp_c    = RSP_ERR;
      rdata_c  = '0;
      we_c     = 1'b0;
      wdata_c  = snp_data_q;
      case (op_q)
         OP_RD: begin
            if (snp_rsp_q == SR_HIT_DIRTY) begin
               we_c    = 1'b1;
               rsp_c   = RSP_GNT_S;
               rdata_c = snp_data_q;
            end else if (snp_rsp_q == SR_HIT_CLEAN) begin
               rsp_c   = RSP_GNT_S;
               rdata_c = mem_rd_c;
            end else begin
               rsp_c   = RSP_GNT_E;
               rdata_c = mem_rd_c;
            end
         end
         OP_RFO: begin
            rsp_c = RSP_GNT_M;
            if (snp_rsp_q == SR_HIT_DIRTY) begin
               we_c    = 1'b1;
               rdata_c = snp_data_q;
            end else begin
               rdata_c = mem_rd_c;
            end
         end
         OP_INV: begin
            rsp_c = RSP_ACK;
            we_c  = (snp_rsp_q == SR_HIT_DIRTY);
         end
         OP_WB: begin
            rsp_c   = RSP_ACK;
            we_c    = 1'b1;
            wdata_c = data_q;
         end
         default: ;
      endcase
   end

   // Backing memory data write, only during a completed MEM cycle
   always_ff @(posedge clk) begin
      if (state_q == ST_MEM && we_c) mem[idx_c] <= wdata_c;
   end

   // Per-block written flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_vld <= '0;
      else if (state_q == ST_MEM && we_c) mem_vld[idx_c] <= 1'b1;
   end

   // Transaction FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         snp_rsp_q     <= '0;
         snp_data_q    <= '0;
         sdreq_ready_q <= 1'b1;
         sureq_valid_q <= 1'b0;
         sureq_op_q    <= '0;
         sdrsp_ready_q <= 1'b0;
         sursp_valid_q <= 1'b0;
         sursp_rsp_q   <= '0;
         sursp_data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.sdreq_valid && sdreq_ready_q) begin
                  op_q          <= bus.sdreq_op;
                  addr_q        <= bus.sdreq_addr;
                  data_q        <= bus.sdreq_data;
                  sdreq_ready_q <= 1'b0;
                  if (bus.sdreq_op == OP_WB) begin
                     state_q <= ST_MEM;
                  end else if (bus.sdreq_op == OP_RD || bus.sdreq_op == OP_RFO ||
                               bus.sdreq_op == OP_INV) begin
                     state_q       <= ST_SNOOP;
                     sureq_valid_q <= 1'b1;
                     sureq_op_q    <= (bus.sdreq_op == OP_RD) ? SNP_RD : SNP_INV;
                  end else begin
                     state_q       <= ST_RSP;
                     sursp_valid_q <= 1'b1;
                     sursp_rsp_q   <= RSP_ERR;
                     sursp_data_q  <= '0;
                  end
               end
            end
            ST_SNOOP: begin
               if (bus.sureq_ready) begin
                  state_q       <= ST_WAIT_SNP;
                  sureq_valid_q <= 1'b0;
                  sureq_op_q    <= '0;
                  sdrsp_ready_q <= 1'b1;
               end
            end
            ST_WAIT_SNP: begin
               if (bus.sdrsp_valid) begin
                  state_q       <= ST_MEM;
                  snp_rsp_q     <= bus.sdrsp_rsp;
                  snp_data_q    <= bus.sdrsp_data;
                  sdrsp_ready_q <= 1'b0;
               end
            end
            ST_MEM: begin
               state_q       <= ST_RSP;
               sursp_valid_q <= 1'b1;
               sursp_rsp_q   <= rsp_c;
               sursp_data_q  <= rdata_c;
            end
            ST_RSP: begin
               if (bus.sursp_ready) begin
                  state_q       <= ST_IDLE;
                  sursp_valid_q <= 1'b0;
                  sursp_rsp_q   <= '0;
                  sursp_data_q  <= '0;
                  op_q          <= '0;
                  addr_q        <= '0;
                  data_q        <= '0;
                  snp_rsp_q     <= '0;
                  snp_data_q    <= '0;
                  sdreq_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               sdreq_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.sdreq_ready = sdreq_ready_q;
   assign bus.sureq_valid = sureq_valid_q;
   assign bus.sureq_op    = sureq_op_q;
   assign bus.sureq_addr  = addr_q;
   assign bus.sdrsp_ready = sdrsp_ready_q;
   assign bus.sursp_valid = sursp_valid_q;
   assign bus.sursp_rsp   = sursp_rsp_q;
   assign bus.sursp_data  = sursp_data_q;

endmodule

// File: tb/tb_snp_bus_ctrl.sv
// Directed bench for snp_bus_ctrl with a reference memory model and a
// response scoreboard.
module tb_snp_bus_ctrl;
   localparam int unsigned BW = 512;
   localparam int unsigned SW = 58;

   typedef struct packed {
      logic [2:0]    rsp;
      logic [BW-1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;

   snp_bus_ctrl_if #(.SADDR_WIDTH(SW), .BLK_WIDTH(BW)) bus ();

   snp_bus_ctrl #(
      .PADDR_WIDTH(64), .BLK_WIDTH(BW), .SADDR_WIDTH(SW), .MEM_DEPTH(4096)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int sureq_xfers = 0;
   int sursp_xfers = 0;

   exp_t          sb_q [$];
   logic [BW-1:0] model_mem [int];

   // Count handshakes on the outbound channels
   always @(posedge clk) begin
      if (bus.sureq_valid && bus.sureq_ready) sureq_xfers <= sureq_xfers + 1;
      if (bus.sursp_valid && bus.sursp_ready) sursp_xfers <= sursp_xfers + 1;
   end

   task automatic check(input string tag, input logic [BW+7:0] obs, input logic [BW+7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of the memory-side decision
   function automatic exp_t model(input logic [2:0] op, input logic [SW-1:0] addr,
                                  input logic [1:0] snp, input logic [BW-1:0] pdata,
                                  input logic [BW-1:0] wdata);
      exp_t e;
      int idx;
      logic [BW-1:0] cur;
      idx = int'(addr[11:0]);
      cur = model_mem.exists(idx) ? model_mem[idx] : '0;
      e.rsp = 3'd4;
      e.data = '0;
      case (op)
         3'd0: begin
            if (snp == 2'd2) begin model_mem[idx] = pdata; e.rsp = 3'd1; e.data = pdata; end
            else if (snp == 2'd1) begin e.rsp = 3'd1; e.data = cur; end
            else begin e.rsp = 3'd2; e.data = cur; end
         end
         3'd1: begin
            e.rsp = 3'd3;
            if (snp == 2'd2) begin model_mem[idx] = pdata; e.data = pdata; end
            else e.data = cur;
         end
         3'd2: begin
            e.rsp = 3'd0;
            if (snp == 2'd2) model_mem[idx] = pdata;
         end
         3'd3: begin
            e.rsp = 3'd0;
            model_mem[idx] = wdata;
         end
         default: ;
      endcase
      return e;
   endfunction

   // One complete transaction; exp_lat < 0 skips the latency check
   task automatic txn(input string tag, input logic [2:0] op, input logic [SW-1:0] addr,
                      input logic [BW-1:0] wdata, input logic [1:0] snp,
                      input logic [BW-1:0] pdata, input int sureq_stall,
                      input int sursp_stall, input int exp_lat);
      exp_t e;
      int   s0, r0, lat;
      bit   snooped;
      snooped = (op <= 3'd2);
      s0 = sureq_xfers;
      r0 = sursp_xfers;
      @(negedge clk);
      check({tag, "_sdreq_ready"}, 520'(bus.sdreq_ready), 520'(1));
      bus.sdreq_valid = 1'b1;
      bus.sdreq_op    = op;
      bus.sdreq_addr  = addr;
      bus.sdreq_data  = wdata;
      bus.sdrsp_valid = 1'b1;
      bus.sdrsp_rsp   = snp;
      bus.sdrsp_data  = pdata;
      bus.sureq_ready = (sureq_stall == 0);
      bus.sursp_ready = (sursp_stall == 0);
      sb_q.push_back(model(op, addr, snp, pdata, wdata));
      @(negedge clk);
      bus.sdreq_valid = 1'b0;
      lat = 1;
      if (snooped) begin
         while (!bus.sureq_valid && lat < 50) begin @(negedge clk); lat++; end
         check({tag, "_sureq_seen"}, 520'(bus.sureq_valid), 520'(1));
         check({tag, "_sureq_op"}, 520'(bus.sureq_op), 520'((op == 3'd0) ? 2'd0 : 2'd1));
         check({tag, "_sureq_addr"}, 520'(bus.sureq_addr), 520'(addr));
         for (int i = 0; i < sureq_stall; i++) begin
            check({tag, "_sureq_hold_v"}, 520'(bus.sureq_valid), 520'(1));
            check({tag, "_sureq_hold_a"}, 520'(bus.sureq_addr), 520'(addr));
            check({tag, "_sureq_hold_rdy"}, 520'(bus.sdreq_ready), 520'(0));
            @(negedge clk);
            lat++;
         end
         bus.sureq_ready = 1'b1;
         @(negedge clk);
         lat++;
         check({tag, "_sureq_drop"}, 520'(bus.sureq_valid), 520'(0));
      end
      while (!bus.sursp_valid && lat < 200) begin @(negedge clk); lat++; end
      check({tag, "_sursp_seen"}, 520'(bus.sursp_valid), 520'(1));
      if (exp_lat >= 0) check({tag, "_latency"}, 520'(lat), 520'(exp_lat));
      e = sb_q.pop_front();
      check({tag, "_rsp"}, 520'(bus.sursp_rsp), 520'(e.rsp));
      check({tag, "_data"}, 520'(bus.sursp_data), 520'(e.data));
      for (int i = 0; i < sursp_stall; i++) begin
         @(negedge clk);
         check({tag, "_sursp_hold_v"}, 520'(bus.sursp_valid), 520'(1));
         check({tag, "_sursp_hold_d"}, 520'(bus.sursp_data), 520'(e.data));
         check({tag, "_sursp_hold_rdy"}, 520'(bus.sdreq_ready), 520'(0));
      end
      bus.sursp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_sursp_drop"}, 520'(bus.sursp_valid), 520'(0));
      check({tag, "_idle_ready"}, 520'(bus.sdreq_ready), 520'(1));
      check({tag, "_n_sureq"}, 520'(sureq_xfers - s0), 520'(snooped ? 1 : 0));
      check({tag, "_n_sursp"}, 520'(sursp_xfers - r0), 520'(1));
      bus.sdrsp_valid = 1'b0;
   endtask

   initial begin
      int lat;
      rst_n           = 1'b0;
      bus.sdreq_valid = 1'b0;
      bus.sdreq_op    = '0;
      bus.sdreq_addr  = '0;
      bus.sdreq_data  = '0;
      bus.sursp_ready = 1'b0;
      bus.sureq_ready = 1'b0;
      bus.sdrsp_valid = 1'b0;
      bus.sdrsp_rsp   = '0;
      bus.sdrsp_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_sdreq_ready", 520'(bus.sdreq_ready), 520'(1));
      check("rst_sureq_valid", 520'(bus.sureq_valid), 520'(0));
      check("rst_sursp_valid", 520'(bus.sursp_valid), 520'(0));
      check("rst_sdrsp_ready", 520'(bus.sdrsp_ready), 520'(0));
      check("rst_sursp_rsp", 520'(bus.sursp_rsp), 520'(0));
      check("rst_sursp_data", 520'(bus.sursp_data), 520'(0));
      check("rst_sureq_addr", 520'(bus.sureq_addr), 520'(0));
      rst_n = 1'b1;

      txn("rd_miss_10", 3'd0, 58'h10, '0, 2'd0, '0, 0, 0, 4);
      txn("wb_5", 3'd3, 58'h5, 512'hA5A5, 2'd0, '0, 0, 0, 2);
      txn("rd_5", 3'd0, 58'h5, '0, 2'd0, '0, 0, 0, 4);
      txn("rd_7_dirty", 3'd0, 58'h7, '0, 2'd2, 512'h1234, 0, 0, 4);
      txn("rd_7_miss", 3'd0, 58'h7, '0, 2'd0, 512'hDEAD, 0, 0, 4);
      txn("wb_9", 3'd3, 58'h9, 512'hBEEF, 2'd0, '0, 0, 0, 2);
      txn("rfo_9_clean", 3'd1, 58'h9, '0, 2'd1, 512'h5555, 0, 0, 4);
      txn("inv_9_dirty", 3'd2, 58'h9, '0, 2'd2, 512'h77, 0, 0, 4);
      txn("rd_9_after_inv", 3'd0, 58'h9, '0, 2'd0, '0, 0, 0, 4);
      txn("rfo_b_dirty", 3'd1, 58'hB, '0, 2'd2, 512'hCAFE, 0, 0, 4);
      txn("rd_b_rsp3", 3'd0, 58'hB, '0, 2'd3, 512'h9999, 0, 0, 4);
      txn("rd_alias_1005", 3'd0, 58'h1005, '0, 2'd1, '0, 0, 0, 4);
      txn("rd_5_stall", 3'd0, 58'h5, '0, 2'd0, '0, 5, 3, -1);
      txn("illegal_5", 3'd5, 58'h3, '0, 2'd0, '0, 0, 0, 1);
      txn("illegal_7", 3'd7, 58'h4, '0, 2'd0, '0, 0, 0, 1);

      // Abort a snooped read while waiting for the peer response
      @(negedge clk);
      bus.sdreq_valid = 1'b1;
      bus.sdreq_op    = 3'd0;
      bus.sdreq_addr  = 58'h20;
      bus.sureq_ready = 1'b1;
      bus.sdrsp_valid = 1'b0;
      bus.sdrsp_rsp   = 2'd2;
      bus.sdrsp_data  = 512'hF00D;
      @(negedge clk);
      bus.sdreq_valid = 1'b0;
      lat = 0;
      while (!bus.sdrsp_ready && lat < 50) begin @(negedge clk); lat++; end
      check("abort_in_wait_snp", 520'(bus.sdrsp_ready), 520'(1));
      rst_n = 1'b0;
      model_mem.delete();
      #1;
      check("abort_sdreq_ready", 520'(bus.sdreq_ready), 520'(1));
      check("abort_sdrsp_ready", 520'(bus.sdrsp_ready), 520'(0));
      check("abort_sursp_valid", 520'(bus.sursp_valid), 520'(0));
      @(negedge clk);
      rst_n = 1'b1;
      txn("rd_20_after_abort", 3'd0, 58'h20, '0, 2'd0, '0, 0, 0, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
